// File: rtl/gfx_pkg.sv
// Shared graphics definitions: draw modes, canvas defaults, pixel FIFO entry
// layout and the pixel-to-framebuffer address helpers.
package gfx_pkg;

    localparam logic [1:0] MODE_SET = 2'd0;
    localparam logic [1:0] MODE_CLR = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam logic [1:0] MODE_NOP = 2'd3;

    localparam int CANVAS_W_DEF   = 64;
    localparam int CANVAS_H_DEF   = 64;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int ADDR_W_DEF     = 9;

    localparam int ENTRY_W = 18;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [1:0] mode;
    } pix_entry_t;

    // Byte address of a pixel in a 1-bpp row-major framebuffer. The multiply
    // is by a constant, so it reduces to a shift when the row is 2^n bytes.
    function automatic logic [15:0] byte_addr(input logic [7:0]  x,
                                              input logic [7:0]  y,
                                              input logic [15:0] bytes_per_row);
        byte_addr = ({8'd0, y} * bytes_per_row) + {11'd0, x[7:3]};
    endfunction

    // One-hot bit select inside a framebuffer byte.
    function automatic logic [7:0] bit_mask(input logic [2:0] bit_idx);
        bit_mask = 8'd1 << bit_idx;
    endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous first-word-fall-through FIFO for queued pixels. The head entry
// is visible on head_o whenever empty_o is low. A push while full is accepted
// only when a pop happens on the same edge.
module pix_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 18,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == CNT_W'(0));
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_ptr_q];
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Storage, pointers and occupancy; everything is cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pixel_plotter.sv
// Pixel sink: queues drawing-engine pixels, clips them to the canvas and
// writes them into a 1-bpp byte-wide framebuffer over a req/gnt port.
// Set/clear are masked writes (same-byte followers merge while waiting for
// the grant); XOR is a read-modify-write.
module pixel_plotter
    import gfx_pkg::*;
#(
    parameter int CANVAS_W   = 64,
    parameter int CANVAS_H   = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic [7:0]        pix_x,
    input  logic [7:0]        pix_y,
    input  logic [1:0]        draw_mode,
    input  logic              clr_ovf,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              ovf
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RD    = 2'd1;
    localparam logic [1:0] ST_RWAIT = 2'd2;
    localparam logic [1:0] ST_WR    = 2'd3;

    logic [ENTRY_W-1:0] fifo_head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CNT_W-1:0]   fifo_cnt_s;
    pix_entry_t         head_s;
    logic               head_clip_s;
    logic [ADDR_W-1:0]  head_addr_s;
    logic [7:0]         head_bit_s;
    logic               pop_s;
    logic               push_ok_s;
    logic               drop_s;
    logic               fifo_busy_next_s;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [7:0]        bit_q, bit_d;
    logic [1:0]        mode_q, mode_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (pix_valid),
        .pop_i   (pop_s),
        .data_i  ({pix_x, pix_y, draw_mode}),
        .head_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_cnt_s)
    );

    assign head_s      = pix_entry_t'(fifo_head_s);
    assign head_clip_s = ({1'b0, head_s.x} >= 9'(CANVAS_W)) ||
                         ({1'b0, head_s.y} >= 9'(CANVAS_H)) ||
                         (head_s.mode == MODE_NOP);
    assign head_addr_s = ADDR_W'(byte_addr(head_s.x, head_s.y, 16'(CANVAS_W / 8)));
    assign head_bit_s  = bit_mask(head_s.x[2:0]);

    // A full FIFO still takes a pixel when the FSM pops on the same edge.
    assign push_ok_s = pix_valid && (!fifo_full_s || pop_s);
    assign drop_s    = pix_valid && fifo_full_s && !pop_s;

    // Whether the FIFO will hold anything after this edge.
    assign fifo_busy_next_s = push_ok_s ||
                              (fifo_cnt_s > CNT_W'(1)) ||
                              ((fifo_cnt_s == CNT_W'(1)) && !pop_s);

    // Access sequencer: pop/clip in IDLE, read-modify-write for XOR, and
    // merging of same-byte same-mode set/clear pixels while a write waits.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        bit_d   = bit_q;
        mode_d  = mode_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    if (head_clip_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d = head_addr_s;
                        bit_d  = head_bit_s;
                        mode_d = head_s.mode;
                        req_d  = 1'b1;
                        if (head_s.mode == MODE_XOR) begin
                            state_d = ST_RD;
                            we_d    = 1'b0;
                            wdata_d = 8'h00;
                            wmask_d = 8'h00;
                        end else begin
                            state_d = ST_WR;
                            we_d    = 1'b1;
                            wmask_d = head_bit_s;
                            wdata_d = (head_s.mode == MODE_SET) ? 8'hFF : 8'h00;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (mem_gnt) begin
                    state_d = ST_RWAIT;
                    req_d   = 1'b0;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_RWAIT: begin
                state_d = ST_WR;
                req_d   = 1'b1;
                we_d    = 1'b1;
                wmask_d = bit_q;
                wdata_d = ~mem_rdata;
            end
            ST_WR: begin
                if (mem_gnt) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                end else if ((mode_q != MODE_XOR) && !fifo_empty_s && !head_clip_s &&
                             (head_s.mode == mode_q) && (head_addr_s == addr_q)) begin
                    pop_s   = 1'b1;
                    wmask_d = wmask_q | head_bit_s;
                end else begin
                    state_d = ST_WR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase
    end

    // Status flags: busy looks ahead one edge, ovf is sticky with drop priority.
    always_comb begin
        busy_d = fifo_busy_next_s || (state_d != ST_IDLE);
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            wmask_q <= 8'h00;
            bit_q   <= 8'h00;
            mode_q  <= MODE_SET;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            bit_q   <= bit_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pixel_plotter.sv
// Bench for pixel_plotter: a byte memory answers the req/gnt port, a
// pixel-level framebuffer model tracks what the canvas must look like, and a
// per-cycle monitor checks request stability while a transfer waits.
module tb_pixel_plotter;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pix_valid;
    logic [7:0]    pix_x;
    logic [7:0]    pix_y;
    logic [1:0]    draw_mode;
    logic          clr_ovf;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_wmask;
    logic          mem_gnt;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic          ovf;

    int checks   = 0;
    int failures = 0;

    logic [7:0]    mem [0:511];
    bit            fb_ref [0:63][0:63];
    int            wr_count;
    int            rd_count;
    logic [AW-1:0] last_wr_addr;
    logic [AW-1:0] last_rd_addr;
    logic [7:0]    last_wr_mask;
    logic [7:0]    last_wr_data;
    bit            gnt_rand;
    logic          gnt_level;

    pixel_plotter #(
        .CANVAS_W   (64),
        .CANVAS_H   (64),
        .FIFO_DEPTH (16),
        .ADDR_W     (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_valid (pix_valid),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .draw_mode (draw_mode),
        .clr_ovf   (clr_ovf),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_gnt   (mem_gnt),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Framebuffer memory: masked writes, read data one cycle after the grant.
    initial begin
        for (int a = 0; a < 512; a++) mem[a] <= 8'h00;
        mem[1]    <= 8'h02;
        mem_rdata <= 8'h00;
        wr_count  <= 0;
        rd_count  <= 0;
        forever begin
            @(posedge clk);
            if (rst_n && mem_req && mem_gnt) begin
                if (mem_we) begin
                    mem[mem_addr] <= (mem[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
                    wr_count      <= wr_count + 1;
                    last_wr_addr  <= mem_addr;
                    last_wr_mask  <= mem_wmask;
                    last_wr_data  <= mem_wdata;
                end else begin
                    mem_rdata    <= mem[mem_addr];
                    rd_count     <= rd_count + 1;
                    last_rd_addr <= mem_addr;
                end
            end
        end
    end

    // Grant driver: a fixed level or a random grant each cycle.
    initial begin
        mem_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_level;
        end
    end

    // Monitor: an ungranted request must hold; only merges may add mask bits.
    initial begin
        logic          p_req;
        logic          p_gnt;
        logic          p_we;
        logic [AW-1:0] p_addr;
        logic [7:0]    p_wdata;
        logic [7:0]    p_wmask;
        p_req = 1'b0;
        p_gnt = 1'b0;
        p_we = 1'b0;
        p_addr = '0;
        p_wdata = 8'h00;
        p_wmask = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && p_req && !p_gnt) begin
                checks++;
                if (!(mem_req && mem_we == p_we && mem_addr == p_addr &&
                      mem_wdata == p_wdata && (mem_wmask & p_wmask) == p_wmask)) begin
                    failures++;
                    $display("FAIL req_hold t=%0t actual req=%b we=%b addr=%0d wdata=%h wmask=%h required req=1 we=%b addr=%0d wdata=%h wmask>=%h",
                             $time, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
                             p_we, p_addr, p_wdata, p_wmask);
                end
            end
            if (rst_n && mem_req && mem_we) begin
                checks++;
                if (mem_wmask == 8'h00) begin
                    failures++;
                    $display("FAIL write_mask t=%0t actual wmask=00 required non-zero", $time);
                end
            end
            p_req   = rst_n && mem_req;
            p_gnt   = mem_gnt;
            p_we    = mem_we;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            p_wmask = mem_wmask;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Canvas model: what a pixel does to the picture, straight from the modes.
    task automatic model_apply(input int x, input int y, input int m);
        if (x < 64 && y < 64) begin
            case (m)
                0:       fb_ref[x][y] = 1'b1;
                1:       fb_ref[x][y] = 1'b0;
                2:       fb_ref[x][y] = !fb_ref[x][y];
                default: ;
            endcase
        end
    endtask

    task automatic push(input int x, input int y, input int m, input bit apply);
        pix_x     = 8'(x);
        pix_y     = 8'(y);
        draw_mode = 2'(m);
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        if (apply) model_apply(x, y, m);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic compare_image();
        for (int a = 0; a < 512; a++) begin
            logic [7:0] e;
            for (int i = 0; i < 8; i++) e[i] = fb_ref[(a % 8) * 8 + i][a / 8];
            checks++;
            if (mem[a] !== e) begin
                failures++;
                $display("FAIL image addr=%0d actual=%h required=%h", a, mem[a], e);
            end
        end
    endtask

    initial begin
        int wr0;
        int rd0;
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 64; y++) fb_ref[x][y] = 1'b0;
        fb_ref[9][0] = 1'b1;
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_x     = 8'd0;
        pix_y     = 8'd0;
        draw_mode = 2'd0;
        clr_ovf   = 1'b0;
        gnt_level = 1'b1;
        gnt_rand  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", int'(mem_req), 0);
        check("rst_we", int'(mem_we), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_wdata", int'(mem_wdata), 0);
        check("rst_wmask", int'(mem_wmask), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovf", int'(ovf), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while an XOR read waits for its grant, with pixels queued.
        gnt_level = 1'b0;
        push(20, 2, 2, 1'b0);
        push(21, 3, 0, 1'b0);
        push(22, 4, 0, 1'b0);
        @(negedge clk);
        check("rd_pending_req", int'(mem_req), 1);
        check("rd_pending_we", int'(mem_we), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_req", int'(mem_req), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ovf", int'(ovf), 0);
        tick();
        rst_n     = 1'b1;
        gnt_level = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("postrst_req", int'(mem_req), 0);
            check("postrst_busy", int'(busy), 0);
        end
        compare_image();

        // Three set pixels in one byte merge while the grant is held low.
        wr0 = wr_count;
        push(3, 5, 0, 1'b1);
        push(4, 5, 0, 1'b1);
        gnt_level = 1'b0;
        push(5, 5, 0, 1'b1);
        tick();
        gnt_level = 1'b1;
        @(negedge clk);
        check("merge_req", int'(mem_req), 1);
        check("merge_we", int'(mem_we), 1);
        check("merge_addr", int'(mem_addr), 40);
        check("merge_wmask", int'(mem_wmask), 'h38);
        check("merge_wdata", int'(mem_wdata), 'hFF);
        wait_idle(50);
        check("merge_writes", wr_count - wr0, 1);
        compare_image();

        // XOR read-modify-write of pixel (9,0) over a byte holding 02.
        wr0 = wr_count;
        rd0 = rd_count;
        push(9, 0, 2, 1'b1);
        wait_idle(50);
        check("xor_reads", rd_count - rd0, 1);
        check("xor_rd_addr", int'(last_rd_addr), 1);
        check("xor_writes", wr_count - wr0, 1);
        check("xor_wr_addr", int'(last_wr_addr), 1);
        check("xor_wr_mask", int'(last_wr_mask), 'h02);
        check("xor_wr_data", int'(last_wr_data), 'hFD);
        compare_image();
        push(9, 0, 2, 1'b1);
        wait_idle(50);
        check("xor2_wr_bit1", int'(last_wr_data[1]), 1);
        check("xor2_wr_data", int'(last_wr_data), 'hFF);
        compare_image();

        // Clipped and no-op pixels never reach memory.
        push(64, 0, 0, 1'b1);
        push(0, 64, 0, 1'b1);
        push(1, 1, 3, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("clip_no_req", int'(mem_req), 0);
        end
        check("clip_busy", int'(busy), 0);

        // Overflow: one write stalls, 16 pixels fill the FIFO, then drops.
        wr0 = wr_count;
        gnt_level = 1'b0;
        push(0, 0, 0, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 16; i++) push(0, i + 1, 0, 1'b1);
        @(negedge clk);
        check("ovf_full_no_drop", int'(ovf), 0);
        push(0, 17, 0, 1'b0);
        @(negedge clk);
        check("ovf_set", int'(ovf), 1);
        clr_ovf = 1'b1;
        push(0, 18, 0, 1'b0);
        clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_drop_beats_clr", int'(ovf), 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", int'(ovf), 0);
        gnt_level = 1'b1;
        wait_idle(300);
        check("ovf_drain_writes", wr_count - wr0, 17);
        compare_image();

        // Random pixels, modes and grants against the canvas model.
        gnt_rand = 1'b1;
        for (int b = 0; b < 25; b++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                int x;
                int y;
                x = $urandom_range(0, 71);
                y = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 70) : $urandom_range(0, 3);
                push(x, y, $urandom_range(0, 3), 1'b1);
                if ($urandom_range(0, 2) == 0) tick();
            end
            wait_idle(500);
        end
        gnt_rand = 1'b0;
        compare_image();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
